// File: rtl/rom_usb_req_pkg.sv
// rom_usb_req_pkg: shared types and constants for the ROM-over-USB fetch block.
//   state_e              - fetch sequencer states
//   ENABLE/DISABLE       - active-high control levels
//   ENABLE_N/DISABLE_N   - active-low control levels
//   sat_inc8             - saturating 8-bit increment
package rom_usb_req_pkg;

  localparam int unsigned BYTE_W = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    RECV = 2'd2,
    RESP = 2'd3
  } state_e;

  localparam logic ENABLE    = 1'b1;
  localparam logic DISABLE   = 1'b0;
  localparam logic ENABLE_N  = 1'b0;
  localparam logic DISABLE_N = 1'b1;

  // Increment that sticks at all-ones.
  function automatic logic [BYTE_W-1:0] sat_inc8(input logic [BYTE_W-1:0] v);
    return (v == {BYTE_W{1'b1}}) ? v : v + BYTE_W'(1);
  endfunction

endpackage

// File: rtl/rom_usb_req_if.sv
// rom_usb_req_if: fetch request / response channel.
//   req_valid/req_ready/req_addr       - request (address) handshake
//   rsp_valid/rsp_ready/rsp_data/err   - response (data) handshake
//   master: requester side, slave: rom_usb_req side
interface rom_usb_req_if
  import rom_usb_req_pkg::*;
#(
  parameter int unsigned ADDR_BYTES = 4,
  parameter int unsigned DATA_BYTES = 8
);

  logic                         req_valid;
  logic                         req_ready;
  logic [BYTE_W*ADDR_BYTES-1:0] req_addr;
  logic                         rsp_valid;
  logic                         rsp_ready;
  logic [BYTE_W*DATA_BYTES-1:0] rsp_data;
  logic                         rsp_err;

  modport master (
    output req_valid, req_addr, rsp_ready,
    input  req_ready, rsp_valid, rsp_data, rsp_err
  );

  modport slave (
    input  req_valid, req_addr, rsp_ready,
    output req_ready, rsp_valid, rsp_data, rsp_err
  );

endinterface

// File: rtl/rom_byte_shifter.sv
// rom_byte_shifter: parallel-to-byte serializer, least-significant byte first.
//   clk, rst_n  - clock, synchronous active-low reset
//   load_i      - capture par_i and restart the byte index
//   par_i       - parallel word to serialize
//   shift_i     - current byte consumed, advance to the next one
//   byte_o      - current byte
//   last_o      - current byte is the final one
module rom_byte_shifter
  import rom_usb_req_pkg::*;
#(
  parameter int unsigned NBYTES = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     load_i,
  input  logic [BYTE_W*NBYTES-1:0] par_i,
  input  logic                     shift_i,
  output logic [BYTE_W-1:0]        byte_o,
  output logic                     last_o
);

  localparam int unsigned IW = (NBYTES > 1) ? $clog2(NBYTES) : 1;

  logic [BYTE_W*NBYTES-1:0] sh_q;
  logic [IW-1:0]            idx_q;

  // Shift register plus byte index; a stalled byte simply is not shifted.
  always_ff @(posedge clk) begin
    if (rst_n == ENABLE_N) begin
      sh_q  <= '0;
      idx_q <= '0;
    end else if (load_i) begin
      sh_q  <= par_i;
      idx_q <= '0;
    end else if (shift_i) begin
      sh_q  <= sh_q >> BYTE_W;
      idx_q <= idx_q + IW'(1);
    end
  end

  assign byte_o = sh_q[BYTE_W-1:0];
  assign last_o = (idx_q == IW'(NBYTES - 1));

endmodule

// File: rtl/rom_usb_req.sv
// rom_usb_req: sends a ROM address over the tx FIFO, collects the reply bytes
// from the rx FIFO and returns them as one response (or an error on timeout).
//   clk, rst_n         - clock, synchronous active-low reset
//   bus (slave)        - request / response channel
//   tx_full/wr_en/din  - write side of the FIFO toward the USB bridge
//   rx_empty/rd_en/dout- read side of the FIFO from the USB bridge (1-cycle latency)
//   drop_cnt           - saturating count of discarded stray rx bytes
module rom_usb_req
  import rom_usb_req_pkg::*;
#(
  parameter int unsigned ADDR_BYTES     = 4,
  parameter int unsigned DATA_BYTES     = 8,
  parameter int unsigned TIMEOUT_CYCLES = 65535
) (
  input  logic              clk,
  input  logic              rst_n,
  rom_usb_req_if.slave      bus,
  input  logic              tx_full,
  output logic              tx_wr_en,
  output logic [BYTE_W-1:0] tx_din,
  input  logic              rx_empty,
  output logic              rx_rd_en,
  input  logic [BYTE_W-1:0] rx_dout,
  output logic [BYTE_W-1:0] drop_cnt
);

  localparam int unsigned DW = BYTE_W * DATA_BYTES;
  localparam int unsigned PW = $clog2(DATA_BYTES + 1);
  localparam int unsigned TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

  state_e            state_q;
  logic              ready_q;
  logic              valid_q;
  logic              err_q;
  logic              pend_q;
  logic [DW-1:0]     data_q;
  logic [PW-1:0]     pop_cnt_q;
  logic [PW-1:0]     cap_cnt_q;
  logic [TW-1:0]     to_cnt_q;
  logic [BYTE_W-1:0] drop_q;

  logic hs_req;
  logic sh_last;
  logic pop_ok;
  logic capture;
  logic last_cap;
  logic timeout;
  logic drop;

  assign hs_req = bus.req_valid & ready_q;

  // FIFO strobes react to the flags in the same cycle, so they are decoded,
  // and forced low while reset is asserted.
  assign tx_wr_en = rst_n & (state_q == SEND) & ~tx_full;

  always_comb begin
    pop_ok = DISABLE;
    case (state_q)
      IDLE, RESP: pop_ok = ~rx_empty;
      RECV:       pop_ok = ~rx_empty & (pop_cnt_q < PW'(DATA_BYTES));
      default:    pop_ok = DISABLE;
    endcase
  end

  assign rx_rd_en = rst_n & pop_ok;

  // pend_q marks that rx_dout carries the byte popped last cycle.
  assign capture  = pend_q & (state_q == RECV);
  assign last_cap = capture & (cap_cnt_q == PW'(DATA_BYTES - 1));
  assign timeout  = (state_q == RECV) & ~capture & (to_cnt_q == TW'(TIMEOUT_CYCLES - 1));
  assign drop     = pend_q & (state_q != RECV);

  rom_byte_shifter #(
    .NBYTES (ADDR_BYTES)
  ) u_shifter (
    .clk     (clk),
    .rst_n   (rst_n),
    .load_i  (hs_req),
    .par_i   (bus.req_addr),
    .shift_i (tx_wr_en),
    .byte_o  (tx_din),
    .last_o  (sh_last)
  );

  // Sequencer, counters and response registers.
  always_ff @(posedge clk) begin
    if (rst_n == ENABLE_N) begin
      state_q   <= IDLE;
      ready_q   <= ENABLE;
      valid_q   <= DISABLE;
      err_q     <= DISABLE;
      pend_q    <= DISABLE;
      data_q    <= '0;
      pop_cnt_q <= '0;
      cap_cnt_q <= '0;
      to_cnt_q  <= '0;
      drop_q    <= '0;
    end else begin
      pend_q <= rx_rd_en;
      if (drop) drop_q <= sat_inc8(drop_q);
      case (state_q)
        IDLE: begin
          if (hs_req) begin
            state_q <= SEND;
            ready_q <= DISABLE;
          end
        end
        SEND: begin
          if (tx_wr_en && sh_last) begin
            state_q   <= RECV;
            pop_cnt_q <= '0;
            cap_cnt_q <= '0;
            to_cnt_q  <= '0;
          end
        end
        RECV: begin
          if (rx_rd_en) pop_cnt_q <= pop_cnt_q + PW'(1);
          if (capture) begin
            // Bytes enter at the top so the first one ends up least significant.
            data_q    <= (data_q >> BYTE_W) | (DW'(rx_dout) << (DW - BYTE_W));
            cap_cnt_q <= cap_cnt_q + PW'(1);
            to_cnt_q  <= '0;
          end else begin
            to_cnt_q <= to_cnt_q + TW'(1);
          end
          if (last_cap) begin
            state_q <= RESP;
            valid_q <= ENABLE;
            err_q   <= DISABLE;
          end else if (timeout) begin
            state_q <= RESP;
            valid_q <= ENABLE;
            err_q   <= ENABLE;
            data_q  <= '0;
          end
        end
        RESP: begin
          if (bus.rsp_ready) begin
            state_q <= IDLE;
            valid_q <= DISABLE;
            ready_q <= ENABLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.req_ready = ready_q;
  assign bus.rsp_valid = valid_q;
  assign bus.rsp_data  = data_q;
  assign bus.rsp_err   = err_q;
  assign drop_cnt      = drop_q;

endmodule

// File: tb/tb_rom_usb_req.sv
// tb_rom_usb_req: directed bench for rom_usb_req with a small FIFO model on
// both sides (rx FIFO has one-cycle read latency).
module tb_rom_usb_req;
  import rom_usb_req_pkg::*;

  localparam int AB = 4;
  localparam int DB = 8;
  localparam int TO = 16;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       tx_full;
  logic       tx_wr_en;
  logic [7:0] tx_din;
  logic       rx_empty;
  logic       rx_rd_en;
  logic [7:0] rx_dout;
  logic [7:0] drop_cnt;

  always #5 clk = ~clk;

  rom_usb_req_if #(.ADDR_BYTES(AB), .DATA_BYTES(DB)) bus ();

  rom_usb_req #(
    .ADDR_BYTES     (AB),
    .DATA_BYTES     (DB),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus      (bus),
    .tx_full  (tx_full),
    .tx_wr_en (tx_wr_en),
    .tx_din   (tx_din),
    .rx_empty (rx_empty),
    .rx_rd_en (rx_rd_en),
    .rx_dout  (rx_dout),
    .drop_cnt (drop_cnt)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Environment state
  logic [7:0] rx_q[$];
  logic [7:0] tx_log[$];
  int         rel;
  bit         stall_en = 0;
  bit         tog_en = 0;
  int         full_left = 0;
  int         inj_rel = -1;
  bit         rsp_load = 0;
  logic [7:0] rsp_base = 8'h00;
  int         pops, underflow, viol, wr_first, wr_last;
  bit         pend;
  logic [7:0] next_dout;

  // Per-cycle observations (taken on the falling edge)
  logic        o_ready, o_valid, o_err, o_wr, o_rd;
  logic [63:0] o_data;
  logic [7:0]  o_din, o_drop;
  int          o_rel;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // One clock: observe at negedge, model the FIFOs, update inputs after posedge.
  task automatic step();
    @(negedge clk);
    o_ready = bus.req_ready;
    o_valid = bus.rsp_valid;
    o_err   = bus.rsp_err;
    o_data  = bus.rsp_data;
    o_wr    = tx_wr_en;
    o_rd    = rx_rd_en;
    o_din   = tx_din;
    o_drop  = drop_cnt;
    o_rel   = rel;
    if (o_wr) begin
      if (tx_full) viol++;
      tx_log.push_back(o_din);
      if (wr_first < 0) wr_first = rel;
      wr_last = rel;
      if (stall_en && tx_log.size() == 1) full_left = 5;
      if (rsp_load && tx_log.size() == AB)
        for (int i = 0; i < DB; i++) rx_q.push_back(rsp_base + 8'(i));
    end
    pend = o_rd;
    if (o_rd) begin
      pops++;
      if (rx_empty) underflow++;
      else next_dout = rx_q.pop_front();
    end
    @(posedge clk);
    #1;
    rel++;
    rx_dout = pend ? next_dout : 8'hEE;
    if (full_left > 0) begin
      tx_full = 1'b1;
      full_left--;
    end else begin
      tx_full = 1'b0;
    end
    if (rel == inj_rel) rx_q.push_back(8'h5A);
    rx_empty = (rx_q.size() == 0) || (tog_en && (rel % 2 == 1));
  endtask

  // Full request/response transaction with checks on every phase.
  task automatic do_req(input string t, input logic [31:0] addr, input bit load,
                        input logic [7:0] base, input int hold, input int exp_lat,
                        input logic [63:0] exp_data, input logic exp_err,
                        input int exp_pops, input int exp_span);
    int          lat;
    int          bad_hold;
    logic [63:0] held;
    logic [31:0] word;
    tx_log.delete();
    pops = 0; underflow = 0; viol = 0; wr_first = -1; wr_last = -1;
    rsp_load = load; rsp_base = base;
    bus.req_valid = 1'b1; bus.req_addr = addr; bus.rsp_ready = 1'b0;
    rel = 0;
    step();
    check($sformatf("%s.req_ready", t), 64'(o_ready), 64'(1));
    bus.req_valid = 1'b0; bus.req_addr = ~addr;
    lat = -1;
    while (lat < 0 && rel < 200) begin
      step();
      if (o_valid) lat = o_rel;
    end
    check($sformatf("%s.latency", t), 64'(lat), 64'(exp_lat));
    check($sformatf("%s.rsp_data", t), o_data, exp_data);
    check($sformatf("%s.rsp_err", t), 64'(o_err), 64'(exp_err));
    word = '0;
    for (int i = 0; i < tx_log.size() && i < AB; i++) word[8*i +: 8] = tx_log[i];
    check($sformatf("%s.tx_count", t), 64'(tx_log.size()), 64'(AB));
    check($sformatf("%s.tx_bytes", t), 64'(word), 64'(addr));
    check($sformatf("%s.tx_first", t), 64'(wr_first), 64'(1));
    check($sformatf("%s.tx_span", t), 64'(wr_last - wr_first), 64'(exp_span));
    check($sformatf("%s.wr_while_full", t), 64'(viol), 64'(0));
    held = o_data;
    bad_hold = 0;
    bus.req_valid = (hold > 0);
    for (int i = 0; i < hold; i++) begin
      step();
      if (o_valid !== 1'b1 || o_data !== held || o_err !== exp_err) bad_hold++;
    end
    check($sformatf("%s.rsp_stable", t), 64'(bad_hold), 64'(0));
    bus.req_valid = 1'b0; bus.rsp_ready = 1'b1;
    step();
    bus.rsp_ready = 1'b0;
    step();
    check($sformatf("%s.idle_ready", t), 64'(o_ready), 64'(1));
    check($sformatf("%s.idle_valid", t), 64'(o_valid), 64'(0));
    check($sformatf("%s.pops", t), 64'(pops), 64'(exp_pops));
    check($sformatf("%s.underflow", t), 64'(underflow), 64'(0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: run did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; tx_full = 1'b0; rx_empty = 1'b0; rx_dout = 8'h00;
    bus.req_valid = 1'b0; bus.req_addr = '0; bus.rsp_ready = 1'b0;
    rel = 0; pops = 0; underflow = 0; viol = 0; wr_first = -1; wr_last = -1;
    pend = 1'b0; next_dout = 8'h00;

    // Reset with a non-empty rx flag: no strobes may escape.
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst.rx_rd_en", 64'(rx_rd_en), 64'(0));
    check("rst.tx_wr_en", 64'(tx_wr_en), 64'(0));
    @(posedge clk);
    #1;
    rst_n = 1'b1; rx_empty = 1'b1;
    step();
    check("rst.req_ready", 64'(o_ready), 64'(1));
    check("rst.rsp_valid", 64'(o_valid), 64'(0));
    check("rst.rsp_err", 64'(o_err), 64'(0));
    check("rst.rsp_data", o_data, 64'(0));
    check("rst.tx_din", 64'(o_din), 64'(0));
    check("rst.rd_en", 64'(o_rd), 64'(0));
    check("rst.drop_cnt", 64'(o_drop), 64'(0));

    // Basic fetch, no stalls
    do_req("basic", 32'h1000_0040, 1, 8'h01, 0, 14, 64'h0807_0605_0403_0201, 1'b0, 8, 3);

    // tx_full stall of 5 cycles after the first byte
    stall_en = 1;
    do_req("txstall", 32'hCAFE_0123, 1, 8'h11, 0, 19, 64'h1817_1615_1413_1211, 1'b0, 8, 8);
    stall_en = 0;

    // rx_empty toggling every cycle
    tog_en = 1;
    do_req("rxtoggle", 32'hDEAD_BEEF, 1, 8'hA1, 0, 22, 64'hA8A7_A6A5_A4A3_A2A1, 1'b0, 8, 3);
    tog_en = 0;

    // rsp_ready held low with req_valid asserted during RESP
    do_req("hold", 32'h0BAD_F00D, 1, 8'h31, 9, 14, 64'h3837_3635_3433_3231, 1'b0, 8, 3);
    step(); step();
    check("hold.no_relatch", 64'(tx_log.size()), 64'(AB));
    check("hold.drop_cnt", 64'(o_drop), 64'(0));

    // Timeout with no rx data, then three stray bytes
    do_req("timeout", 32'h2000_0000, 0, 8'h00, 0, 21, 64'(0), 1'b1, 0, 3);
    check("timeout.drop0", 64'(o_drop), 64'(0));
    for (int i = 0; i < 3; i++) rx_q.push_back(8'hC0 + 8'(i));
    repeat (8) step();
    check("stray.drop_cnt", 64'(o_drop), 64'(3));

    // Pop issued in the very cycle the timeout fires is discarded
    inj_rel = 20;
    do_req("tmo_pop", 32'h3000_0000, 0, 8'h00, 0, 21, 64'(0), 1'b1, 1, 3);
    inj_rel = -1;
    check("tmo_pop.drop_cnt", 64'(o_drop), 64'(4));

    // Reset pulse mid-SEND
    tx_log.delete(); wr_first = -1;
    bus.req_valid = 1'b1; bus.req_addr = 32'h4444_4444; rel = 0;
    step();
    bus.req_valid = 1'b0;
    step();
    rx_q.push_back(8'h77); rx_empty = 1'b0; rst_n = 1'b0;
    step();
    check("midrst.wr_in_reset", 64'(o_wr), 64'(0));
    check("midrst.rd_in_reset", 64'(o_rd), 64'(0));
    rst_n = 1'b1;
    step();
    check("midrst.req_ready", 64'(o_ready), 64'(1));
    check("midrst.rsp_valid", 64'(o_valid), 64'(0));
    check("midrst.rsp_data", o_data, 64'(0));
    check("midrst.tx_wr_en", 64'(o_wr), 64'(0));
    check("midrst.tx_din", 64'(o_din), 64'(0));
    check("midrst.drop_cnt", 64'(o_drop), 64'(0));
    repeat (4) step();
    check("midrst.stray_drop", 64'(o_drop), 64'(1));

    do_req("after_rst", 32'h0000_00FF, 1, 8'h51, 0, 14, 64'h5857_5655_5453_5251, 1'b0, 8, 3);
    check("after_rst.drop_cnt", 64'(o_drop), 64'(1));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/rom_usb_req.md
ROM_USB_REQ -- requirements
Module: rom_usb_req

Interface
REQ-001 The block SHALL have parameter ADDR_BYTES, default 4, meaning number of address bytes sent per request.
REQ-002 The block SHALL have parameter DATA_BYTES, default 8, meaning number of data bytes collected per response.
REQ-003 The block SHALL have parameter TIMEOUT_CYCLES, default 65535, meaning idle cycles in RECV before an error response.
REQ-004 The block SHALL have port clk  input  1  single clock; all logic on its rising edge.
REQ-005 The block SHALL have port rst_n  input  1  synchronous active-low reset.
REQ-006 The block SHALL have ports req_valid  input  1, req_ready  output  1, req_addr  input  8*ADDR_BYTES: the fetch request channel.
REQ-007 The block SHALL have ports rsp_valid  output  1, rsp_ready  input  1, rsp_data  output  8*DATA_BYTES, rsp_err  output  1: the response channel.
REQ-008 The block SHALL have ports tx_full  input  1, tx_wr_en  output  1, tx_din  output  8: the write side of the FIFO drained toward the USB bridge.
REQ-009 The block SHALL have ports rx_empty  input  1, rx_rd_en  output  1, rx_dout  input  8: the read side of the FIFO filled by the USB bridge.
REQ-010 The block SHALL have port drop_cnt  output  8: saturating count of discarded stray rx bytes.

Function
REQ-011 The FSM SHALL have states IDLE, SEND, RECV, RESP.
REQ-012 req_ready SHALL be 1 only in IDLE; a handshake (req_valid & req_ready) SHALL latch req_addr and move to SEND.
REQ-013 In SEND, tx_wr_en SHALL be asserted each cycle tx_full=0, writing address bytes least-significant first, one byte per write.
REQ-014 tx_wr_en SHALL never be asserted while tx_full=1; a full stall SHALL hold the current byte index.
REQ-015 After the write of byte ADDR_BYTES-1, the FSM SHALL enter RECV on the next cycle.
REQ-016 In RECV, rx_rd_en SHALL equal ~rx_empty while issued pops < DATA_BYTES, and 0 otherwise.
REQ-017 The FIFO has one-cycle read latency; rx_dout SHALL be captured the cycle after each pop, filling rsp_data least-significant byte first.
REQ-018 When the DATA_BYTES-th byte is captured, the FSM SHALL enter RESP with rsp_err=0.
REQ-019 The timeout counter SHALL clear on RECV entry and on every capture; on reaching TIMEOUT_CYCLES-1 with no capture, the FSM SHALL enter RESP with rsp_err=1 and rsp_data all zero.
REQ-020 In RESP, rsp_valid SHALL be 1 and rsp_data/rsp_err held stable until rsp_ready=1; the FSM SHALL return to IDLE the cycle after the handshake.
REQ-021 A pop issued in the same cycle the timeout fires SHALL have its data discarded and counted in drop_cnt.
REQ-022 In IDLE and RESP, rx_rd_en SHALL equal ~rx_empty; every byte so popped SHALL be discarded and increment drop_cnt, saturating at 255.
REQ-023 req_valid asserted outside IDLE SHALL be ignored (not latched).
REQ-024 Request-to-response latency with zero FIFO stalls SHALL be ADDR_BYTES + DATA_BYTES + 2 cycles from request handshake to rsp_valid.

Reset
REQ-025 While rst_n=0 at a clock edge, the FSM SHALL go to IDLE and counters, byte indices and drop_cnt SHALL clear, including mid-transaction.
REQ-026 Reset values SHALL be: req_ready=1 after release, rsp_valid=0, rsp_err=0, rsp_data=0, tx_wr_en=0, tx_din=0, rx_rd_en=0, drop_cnt=0.
REQ-027 During reset, tx_wr_en and rx_rd_en SHALL be 0 regardless of FIFO flags.

Structure
REQ-028 The FSM state enum and the ENABLE/DISABLE, ENABLE_N/DISABLE_N constants SHALL come from the shared r_rom package.
REQ-029 One sub-module, rom_byte_shifter (parallel-to-byte serializer for the address), SHALL be used; the remainder stays flat.
REQ-030 State and data registers SHALL use the codebase dff primitive or a single clocked process; no latches.

Verification
REQ-031 Addr 0x1000_0040, FIFOs never stall -> tx_din 0x40,0x00,0x00,0x10 on consecutive cycles; rx bytes 0x01..0x08 -> rsp_data 0x0807_0605_0403_0201, rsp_err=0, latency 14 cycles.
REQ-032 tx_full high for 5 cycles after first byte -> no write during stall; byte order and count unchanged.
REQ-033 rx_empty toggling every cycle during RECV -> all 8 bytes assembled correctly, no extra pop.
REQ-034 TIMEOUT_CYCLES=16, no rx data -> rsp_valid with rsp_err=1, rsp_data=0 at 16 cycles into RECV; later 3 stray bytes -> drop_cnt=3.
REQ-035 rsp_ready held low 10 cycles -> rsp_valid/rsp_data stable; req_valid asserted meanwhile is ignored.
REQ-036 rst_n low for one cycle mid-SEND -> next cycle IDLE, all outputs at reset values, next request runs normally.
